// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the sub-word memory access unit: op encodings,
// sequencer states and a small op-classification helper.
package mem_access_unit_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      MEM_LW  = 3'd0,
      MEM_LH  = 3'd1,
      MEM_LHU = 3'd2,
      MEM_LB  = 3'd3,
      MEM_LBU = 3'd4,
      MEM_SW  = 3'd5,
      MEM_SH  = 3'd6,
      MEM_SB  = 3'd7
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   function automatic logic is_load(input logic [2:0] op);
      return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
             (op == MEM_LB) || (op == MEM_LBU);
   endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational byte-lane logic: alignment check, load extension and
// read-modify-write merge of a sub-word store into a fetched word.
module byte_lane_unit
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [1:0]        addr_lo,
   input  logic [WORD_W-1:0] word,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_ext,
   output logic [WORD_W-1:0] merged,
   output logic              misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Little-endian lanes: byte offset 0 is bits [7:0], half at offset 2 is bits [31:16].
   always_comb begin
      byte_sel   = word[{addr_lo, 3'b000} +: 8];
      half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
      load_ext   = '0;
      merged     = word;
      misaligned = 1'b0;
      case (op)
         MEM_LW: begin
            load_ext   = word;
            misaligned = (addr_lo != 2'b00);
         end
         MEM_LH: begin
            load_ext   = {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         MEM_LHU: begin
            load_ext   = {16'h0000, half_sel};
            misaligned = addr_lo[0];
         end
         MEM_LB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         MEM_LBU: load_ext = {24'h000000, byte_sel};
         MEM_SW: begin
            merged     = wdata;
            misaligned = (addr_lo != 2'b00);
         end
         MEM_SH: begin
            misaligned = addr_lo[0];
            if (addr_lo[1])
               merged[31:16] = wdata[15:0];
            else
               merged[15:0] = wdata[15:0];
         end
         MEM_SB:  merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word memory access sequencer between the MEM stage and a word-only
// data memory: handshake, alignment errors, load extension and sh/sb RMW.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [31:0]       req_pc,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              dm_read,
   output logic              dm_write,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wd,
   output logic [31:0]       dm_pc,
   input  logic [DATA_W-1:0] dm_rd
);

   state_t            state;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] merge_q;
   logic [DATA_W-1:0] rdata_q;
   logic [31:0]       pc_q;
   logic              err_q;

   logic [2:0]        lane_op;
   logic [1:0]        lane_lo;
   logic [DATA_W-1:0] lane_load;
   logic [DATA_W-1:0] lane_merged;
   logic              lane_misaligned;

   // In IDLE the lane unit classifies the incoming request; afterwards it works on the latched one.
   assign lane_op = (state == IDLE) ? req_op : op_q;
   assign lane_lo = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];

   byte_lane_unit u_lanes (
      .op         (lane_op),
      .addr_lo    (lane_lo),
      .word       (dm_rd),
      .wdata      (wdata_q),
      .load_ext   (lane_load),
      .merged     (lane_merged),
      .misaligned (lane_misaligned)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         pc_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  pc_q    <= req_pc;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  if (lane_misaligned) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else if (req_op == MEM_SW) begin
                     merge_q <= req_wdata;
                     state   <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               if (is_load(op_q)) begin
                  rdata_q <= lane_load;
                  state   <= RESP;
               end else begin
                  merge_q <= lane_merged;
                  state   <= WR;
               end
            end
            WR:      state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The write strobe is masked by reset so an abort during WR never reaches memory.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dm_read    = (state == RD);
   assign dm_write   = (state == WR) && !reset;
   assign dm_addr    = {addr_q[ADDR_W-1:2], 2'b00};
   assign dm_wd      = merge_q;
   assign dm_pc      = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand-written
// reset-abort and back-to-back sequences, and randomized ops vs a byte-level model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic [31:0] dm_pc;
   logic [31:0] dm_rd;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .dm_read    (dm_read),
      .dm_write   (dm_write),
      .dm_addr    (dm_addr),
      .dm_wd      (dm_wd),
      .dm_pc      (dm_pc),
      .dm_rd      (dm_rd)
   );

   // Word-only data memory: combinational read, write on posedge; preload port for the bench.
   logic [31:0] dmem [0:63];
   logic        tb_wr_en;
   logic [5:0]  tb_wr_idx;
   logic [31:0] tb_wr_data;

   assign dm_rd = dmem[dm_addr[7:2]];

   always @(posedge clk) begin
      if (dm_write)
         dmem[dm_addr[7:2]] <= dm_wd;
      else if (tb_wr_en)
         dmem[tb_wr_idx] <= tb_wr_data;
   end

   // Reference model: memory as a flat little-endian byte array.
   logic [7:0] ref_mem [0:255];

   task automatic ref_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int reads, output int writes);
      int     a;
      longint v;
      a      = int'(addr[7:0]);
      rdata  = 32'h0;
      reads  = 0;
      writes = 0;
      case (op)
         MEM_LW, MEM_SW:           err = (a % 4) != 0;
         MEM_LH, MEM_LHU, MEM_SH:  err = (a % 2) != 0;
         default:                  err = 1'b0;
      endcase
      if (err) begin
         lat = 1;
         return;
      end
      case (op)
         MEM_LW: begin
            v = 0;
            for (int k = 0; k < 4; k++) v += longint'(ref_mem[a + k]) << (8 * k);
            rdata = 32'(v);
         end
         MEM_LH, MEM_LHU: begin
            v = longint'(ref_mem[a]) + 256 * longint'(ref_mem[a + 1]);
            if (op == MEM_LH && v >= 32768) v -= 65536;
            rdata = 32'(v);
         end
         MEM_LB, MEM_LBU: begin
            v = longint'(ref_mem[a]);
            if (op == MEM_LB && v >= 128) v -= 256;
            rdata = 32'(v);
         end
         MEM_SW: for (int k = 0; k < 4; k++) ref_mem[a + k] = 8'((wdata >> (8 * k)) & 32'hFF);
         MEM_SH: for (int k = 0; k < 2; k++) ref_mem[a + k] = 8'((wdata >> (8 * k)) & 32'hFF);
         default: ref_mem[a] = wdata[7:0];
      endcase
      if (op == MEM_SW) lat = 2;
      else if (op == MEM_SH || op == MEM_SB) lat = 3;
      else lat = 2;
      reads  = (op == MEM_SW) ? 0 : 1;
      writes = (op == MEM_SW || op == MEM_SH || op == MEM_SB) ? 1 : 0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issues one request from an IDLE negedge and observes it until its response.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] pc, output logic [31:0] rdata, output logic err,
                                output int lat, output int reads, output int writes,
                                output logic overlap, output logic bad_addr, output logic bad_pc,
                                output logic stuck);
      bit done;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = pc;
      req_valid = 1'b1;
      rdata = 32'h0; err = 1'b0; lat = 0; reads = 0; writes = 0;
      overlap = 1'b0; bad_addr = 1'b0; bad_pc = 1'b0; done = 1'b0;
      while (!done && lat < 12) begin
         @(negedge clk);
         lat++;
         if (lat == 1) req_valid = 1'b0;
         if (dm_read && dm_write) overlap = 1'b1;
         if (dm_read) reads++;
         if (dm_write) writes++;
         if ((dm_read || dm_write) && dm_addr !== {addr[31:2], 2'b00}) bad_addr = 1'b1;
         if ((dm_read || dm_write) && dm_pc !== pc) bad_pc = 1'b1;
         if (resp_valid) begin
            rdata = resp_rdata;
            err   = resp_err;
            done  = 1'b1;
         end
      end
      if (!done) lat = 99;
      @(negedge clk);
      stuck = resp_valid;
   endtask

   task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input int exp_reads, input int exp_writes);
      logic [31:0] rdata;
      logic        err, overlap, bad_addr, bad_pc, stuck;
      int          lat, reads, writes;
      applyStimulus(op, addr, wdata, pc, rdata, err, lat, reads, writes, overlap, bad_addr, bad_pc, stuck);
      checkOutput({tag, " rdata"}, rdata, exp_rdata);
      checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
      checkOutput({tag, " latency"}, lat, exp_lat);
      checkOutput({tag, " dm_read cycles"}, reads, exp_reads);
      checkOutput({tag, " dm_write cycles"}, writes, exp_writes);
      checkOutput({tag, " read/write overlap"}, 32'(overlap), 32'h0);
      checkOutput({tag, " dm_addr"}, 32'(bad_addr), 32'h0);
      checkOutput({tag, " dm_pc"}, 32'(bad_pc), 32'h0);
      checkOutput({tag, " resp_valid one cycle"}, 32'(stuck), 32'h0);
   endtask

   task automatic model_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc);
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat, exp_reads, exp_writes;
      ref_op(op, addr, wdata, exp_rdata, exp_err, exp_lat, exp_reads, exp_writes);
      check_op(tag, op, addr, wdata, pc, exp_rdata, exp_err, exp_lat, exp_reads, exp_writes);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_reads;
      int          exp_writes;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] dummy_r, x_word;
      logic        dummy_e;
      int          dummy_l, dummy_rd, dummy_wr;

      vecs[0]  = '{MEM_LB,  32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1, 0};
      vecs[1]  = '{MEM_LBU, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 1, 0};
      vecs[2]  = '{MEM_SH,  32'h12, 32'h00001234, 32'h0,        1'b0, 3, 1, 1};
      vecs[3]  = '{MEM_LW,  32'h10, 32'h0,        32'h1234AABB, 1'b0, 2, 1, 0};
      vecs[4]  = '{MEM_SW,  32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1};
      vecs[5]  = '{MEM_LHU, 32'h22, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0};
      vecs[6]  = '{MEM_LW,  32'h21, 32'h0,        32'h0,        1'b1, 1, 0, 0};
      vecs[7]  = '{MEM_SH,  32'h13, 32'h0000FFFF, 32'h0,        1'b1, 1, 0, 0};
      vecs[8]  = '{MEM_LW,  32'h10, 32'h0,        32'h1234AABB, 1'b0, 2, 1, 0};
      vecs[9]  = '{MEM_LH,  32'h22, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, 0};
      vecs[10] = '{MEM_SB,  32'h23, 32'h0000005A, 32'h0,        1'b0, 3, 1, 1};
      vecs[11] = '{MEM_LW,  32'h20, 32'h0,        32'h5AADBEEF, 1'b0, 2, 1, 0};
      vecs[12] = '{MEM_LH,  32'h12, 32'h0,        32'h00001234, 1'b0, 2, 1, 0};

      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
      req_wdata = 32'h0; req_pc = 32'h0; tb_wr_en = 1'b0; tb_wr_idx = 6'd0; tb_wr_data = 32'h0;

      // Preload memory and model under reset; word 0x10 holds the directed pattern.
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         tb_wr_en   = 1'b1;
         tb_wr_idx  = 6'(i);
         tb_wr_data = (i == 4) ? 32'h8899AABB : $urandom;
         for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = tb_wr_data[8 * k +: 8];
      end
      @(negedge clk);
      tb_wr_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      checkOutput("reset req_ready", 32'(req_ready), 32'h1);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("reset resp_rdata", resp_rdata, 32'h0);
      checkOutput("reset resp_err", 32'(resp_err), 32'h0);
      checkOutput("reset dm_read", 32'(dm_read), 32'h0);
      checkOutput("reset dm_write", 32'(dm_write), 32'h0);
      checkOutput("reset dm_addr", dm_addr, 32'h0);
      checkOutput("reset dm_wd", dm_wd, 32'h0);
      checkOutput("reset dm_pc", dm_pc, 32'h0);

      for (int i = 0; i < 13; i++) begin
         ref_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, dummy_r, dummy_e, dummy_l, dummy_rd, dummy_wr);
         check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                  32'h1000 + 32'(4 * i), vecs[i].exp_rdata, vecs[i].exp_err,
                  vecs[i].exp_lat, vecs[i].exp_reads, vecs[i].exp_writes);
      end

      // sh write data must be the fetched word with only the upper half replaced.
      req_op = MEM_SH; req_addr = 32'h12; req_wdata = 32'hCAFE4321; req_pc = 32'h2000; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("sh rd phase", 32'(dm_read), 32'h1);
      @(negedge clk);
      checkOutput("sh wr phase", 32'(dm_write), 32'h1);
      checkOutput("sh merged dm_wd", dm_wd, 32'h4321AABB);
      @(negedge clk);
      checkOutput("sh resp_valid", 32'(resp_valid), 32'h1);
      @(negedge clk);
      ref_op(MEM_SH, 32'h12, 32'hCAFE4321, dummy_r, dummy_e, dummy_l, dummy_rd, dummy_wr);

      // Reset during the WR cycle of an sb aborts it without a write or a response.
      req_op = MEM_SB; req_addr = 32'h30; req_wdata = 32'h00000077; req_pc = 32'h3000; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("abort rd phase", 32'(dm_read), 32'h1);
      @(negedge clk);
      checkOutput("abort wr phase", 32'(dm_write), 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("abort dm_write gated", 32'(dm_write), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort resp_valid", 32'(resp_valid), 32'h0);
      @(negedge clk);
      checkOutput("abort req_ready", 32'(req_ready), 32'h1);
      checkOutput("abort no late resp", 32'(resp_valid), 32'h0);
      model_op("abort readback", MEM_LW, 32'h30, 32'h0, 32'h3004);

      // Back-to-back: valid held high; second request waits for the cycle after resp_valid.
      x_word = $urandom;
      req_op = MEM_SW; req_addr = 32'h40; req_wdata = x_word; req_pc = 32'h4000; req_valid = 1'b1;
      ref_op(MEM_SW, 32'h40, x_word, dummy_r, dummy_e, dummy_l, dummy_rd, dummy_wr);
      @(negedge clk);
      checkOutput("b2b ready in WR", 32'(req_ready), 32'h0);
      checkOutput("b2b write", 32'(dm_write), 32'h1);
      checkOutput("b2b sw no read", 32'(dm_read), 32'h0);
      @(negedge clk);
      checkOutput("b2b first resp", 32'(resp_valid), 32'h1);
      checkOutput("b2b ready in RESP", 32'(req_ready), 32'h0);
      req_op = MEM_LW; req_addr = 32'h40; req_wdata = 32'h0; req_pc = 32'h4004;
      @(negedge clk);
      checkOutput("b2b ready after resp", 32'(req_ready), 32'h1);
      checkOutput("b2b idle no resp", 32'(resp_valid), 32'h0);
      checkOutput("b2b idle no read", 32'(dm_read), 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("b2b ready in RD", 32'(req_ready), 32'h0);
      checkOutput("b2b second read", 32'(dm_read), 32'h1);
      @(negedge clk);
      checkOutput("b2b second resp", 32'(resp_valid), 32'h1);
      checkOutput("b2b second rdata", resp_rdata, x_word);
      checkOutput("b2b second err", 32'(resp_err), 32'h0);
      @(negedge clk);

      for (int n = 0; n < 300; n++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         op   = 3'($urandom_range(0, 7));
         addr = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 255))};
         if ($urandom_range(0, 3) != 0) begin
            if (op == MEM_LW || op == MEM_SW) addr[1:0] = 2'b00;
            else if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) addr[0] = 1'b0;
         end
         model_op($sformatf("rand%0d", n), op, addr, $urandom, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
